// File: rtl/uart_rx_ext_if.sv
// Receive-side word handshake between uart_rx_ext and its consumer.
// The UART acts as master (drives data/valid), the consumer as slave (drives ready).
interface uart_rx_ext_if #(
    parameter int MAX_DATA_WIDTH = 8
);
    logic [MAX_DATA_WIDTH-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: 5..8 data bits, optional parity, 1/2 stop bits, valid/ready output.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_ext #(
    parameter int MAX_DATA_WIDTH  = 8,
    parameter int OVERSAMPLE_RATE = 16
) (
    input  logic          uart_clk,
    input  logic          rst_n,
    input  logic          sample_tick,
    input  logic          rx_serial_sync,
    input  logic [1:0]    cfg_data_bits,
    input  logic          cfg_parity_en,
    input  logic          cfg_parity_odd,
    input  logic          cfg_stop2,
    uart_rx_ext_if.master rx_if,
    output logic          frame_error,
    output logic          parity_error,
    output logic          overrun_error,
    output logic          break_detect,
    output logic          rx_active
);
    localparam int CNT_W = $clog2(OVERSAMPLE_RATE);
    localparam logic [CNT_W-1:0] CNT_V0   = CNT_W'(OVERSAMPLE_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_V1   = CNT_W'(OVERSAMPLE_RATE / 2);
    localparam logic [CNT_W-1:0] CNT_V2   = CNT_W'(OVERSAMPLE_RATE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE_RATE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
`ifdef UART_RX_BREAK_DETECT_EN
        , BRK_WAIT
`endif
    } state_t;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Index of the last data bit, with lengths beyond the build width clamped.
    function automatic logic [2:0] last_index(input logic [1:0] cfg);
        int n;
        n = int'(cfg) + 4;
        if (n > MAX_DATA_WIDTH - 1) n = MAX_DATA_WIDTH - 1;
        return 3'(n);
    endfunction

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [2:0]                last_idx_q, last_idx_d;
    logic                      par_en_q, par_en_d;
    logic                      par_odd_q, par_odd_d;
    logic                      stop2_q, stop2_d;
    logic [MAX_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                      s0_q, s0_d;
    logic                      s1_q, s1_d;
    logic                      prev_line_q, prev_line_d;
    logic                      par_err_frame_q, par_err_frame_d;
    logic [MAX_DATA_WIDTH-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      parity_err_q, parity_err_d;
    logic                      overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                      brk_q, brk_d;
    logic                      all_zero_q, all_zero_d;
`endif

    logic voted;
    logic decide;
    logic wrap;
    logic load;
    logic accept;

    assign voted  = vote3(s0_q, s1_q, rx_serial_sync);
    assign decide = (cnt_q == CNT_V2);
    assign wrap   = (cnt_q == CNT_LAST);
    assign accept = valid_q && rx_if.rx_ready;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_cnt_d       = bit_cnt_q;
        last_idx_d      = last_idx_q;
        par_en_d        = par_en_q;
        par_odd_d       = par_odd_q;
        stop2_d         = stop2_q;
        shreg_d         = shreg_q;
        s0_d            = s0_q;
        s1_d            = s1_q;
        prev_line_d     = prev_line_q;
        par_err_frame_d = par_err_frame_q;
        data_d          = data_q;
        valid_d         = valid_q;
        frame_err_d     = frame_err_q;
        parity_err_d    = parity_err_q;
        overrun_d       = overrun_q;
        load            = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_d           = brk_q;
        all_zero_d      = all_zero_q;
`endif

        if (sample_tick) begin
            prev_line_d = rx_serial_sync;
            if (state_q != IDLE) cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_V0) s0_d = rx_serial_sync;
            if (cnt_q == CNT_V1) s1_d = rx_serial_sync;

            unique case (state_q)
                IDLE: begin
                    if (prev_line_q && !rx_serial_sync) begin
                        state_d         = START;
                        cnt_d           = '0;
                        bit_cnt_d       = '0;
                        shreg_d         = '0;
                        par_err_frame_d = 1'b0;
                        last_idx_d      = last_index(cfg_data_bits);
                        par_en_d        = cfg_parity_en;
                        par_odd_d       = cfg_parity_odd;
                        stop2_d         = cfg_stop2;
`ifdef UART_RX_BREAK_DETECT_EN
                        all_zero_d      = 1'b1;
`endif
                    end
                end
                START: begin
                    if (decide && voted) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (wrap) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg_d[bit_cnt_q] = voted;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (voted) all_zero_d = 1'b0;
`endif
                    end
                    if (wrap) begin
                        if (bit_cnt_q == last_idx_q) begin
                            bit_cnt_d = '0;
                            state_d   = par_en_q ? PARITY : STOP1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (decide) begin
                        par_err_frame_d = (^shreg_q) ^ voted ^ par_odd_q;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (voted) all_zero_d = 1'b0;
`endif
                    end
                    if (wrap) state_d = STOP1;
                end
                STOP1: begin
                    if (decide) begin
                        parity_err_d = par_en_q & par_err_frame_q;
                        if (voted) begin
                            load        = 1'b1;
                            data_d      = shreg_q;
                            frame_err_d = 1'b0;
                            if (stop2_q) begin
                                state_d = STOP2;
                            end else begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                            cnt_d       = '0;
`ifdef UART_RX_BREAK_DETECT_EN
                            // An all-zero frame is a break, not a framing fault.
                            if (all_zero_q) begin
                                frame_err_d  = frame_err_q;
                                parity_err_d = parity_err_q;
                                brk_d        = 1'b1;
                                state_d      = BRK_WAIT;
                            end
`endif
                        end
                    end
                end
                STOP2: begin
                    if (decide) begin
                        if (!voted) frame_err_d = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BRK_WAIT: begin
                    if (rx_serial_sync) begin
                        brk_d   = 1'b0;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // The handshake runs every clock, independent of sample_tick.
        if (load) begin
            valid_d = 1'b1;
            if (valid_q && !accept) overrun_d = 1'b1;
            else if (accept)        overrun_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_cnt_q       <= '0;
            last_idx_q      <= '0;
            par_en_q        <= 1'b0;
            par_odd_q       <= 1'b0;
            stop2_q         <= 1'b0;
            shreg_q         <= '0;
            s0_q            <= 1'b1;
            s1_q            <= 1'b1;
            prev_line_q     <= 1'b1;
            par_err_frame_q <= 1'b0;
            data_q          <= '0;
            valid_q         <= 1'b0;
            frame_err_q     <= 1'b0;
            parity_err_q    <= 1'b0;
            overrun_q       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q           <= 1'b0;
            all_zero_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            last_idx_q      <= last_idx_d;
            par_en_q        <= par_en_d;
            par_odd_q       <= par_odd_d;
            stop2_q         <= stop2_d;
            shreg_q         <= shreg_d;
            s0_q            <= s0_d;
            s1_q            <= s1_d;
            prev_line_q     <= prev_line_d;
            par_err_frame_q <= par_err_frame_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            frame_err_q     <= frame_err_d;
            parity_err_q    <= parity_err_d;
            overrun_q       <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q           <= brk_d;
            all_zero_q      <= all_zero_d;
`endif
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign frame_error    = frame_err_q;
    assign parity_error   = parity_err_q;
    assign overrun_error  = overrun_q;
    assign rx_active      = (state_q != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_detect   = brk_q;
`else
    assign break_detect   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: directed frame table, corner sequences, random frames.
module tb_uart_rx_ext;
    localparam int OSR = 16;

    logic       uart_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx_serial_sync = 1'b1;
    logic [1:0] cfg_data_bits = 2'd3;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       frame_error, parity_error, overrun_error, break_detect, rx_active;

    uart_rx_ext_if #(.MAX_DATA_WIDTH(8)) rx_if ();

    uart_rx_ext #(.MAX_DATA_WIDTH(8), .OVERSAMPLE_RATE(OSR)) dut (
        .uart_clk       (uart_clk),
        .rst_n          (rst_n),
        .sample_tick    (sample_tick),
        .rx_serial_sync (rx_serial_sync),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_if          (rx_if.master),
        .frame_error    (frame_error),
        .parity_error   (parity_error),
        .overrun_error  (overrun_error),
        .break_detect   (break_detect),
        .rx_active      (rx_active)
    );

    always #5 uart_clk = ~uart_clk;

    // Handshake monitor: counts accepted words and valid-high cycles.
    int         hs_cnt = 0;
    int         vcyc = 0;
    logic [7:0] last_data = '0;
    logic       last_perr = 1'b0;
    logic       last_ovr = 1'b0;

    always @(negedge uart_clk) begin
        if (rst_n && rx_if.rx_valid) vcyc <= vcyc + 1;
        if (rst_n && rx_if.rx_valid && rx_if.rx_ready) begin
            hs_cnt    <= hs_cnt + 1;
            last_data <= rx_if.rx_data;
            last_perr <= parity_error;
            last_ovr  <= overrun_error;
        end
    end

    int total = 0;
    int bad = 0;
    int ctx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, ctx, act, exp);
        end
    endtask

    task automatic tick(input logic v);
        @(negedge uart_clk);
        rx_serial_sync = v;
        sample_tick = 1'b1;
        @(negedge uart_clk);
        sample_tick = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge uart_clk);
    endtask

    task automatic send_bit(input logic v);
        repeat (OSR) tick(v);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                              input bit st2, input bit pflip, input bit s1v, input bit s2v);
        logic [7:0] m;
        m = 8'((9'd1 << nb) - 9'd1);
        cfg_data_bits  = 2'(nb - 5);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = st2;
        send_bit(1'b0);
        // Config is scrambled mid-frame; the receiver must keep what it latched.
        cfg_data_bits  = 2'($urandom_range(0, 3));
        cfg_parity_en  = 1'($urandom_range(0, 1));
        cfg_parity_odd = 1'($urandom_range(0, 1));
        cfg_stop2      = 1'($urandom_range(0, 1));
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pen) send_bit((^(d & m)) ^ podd ^ pflip);
        send_bit(s1v);
        if (st2) send_bit(s2v);
        repeat (8) tick(1'b1);
    endtask

    typedef struct {
        logic [7:0] d;
        int         nb;
        bit         pen, podd, st2, pflip, s1v, s2v;
        logic [7:0] exp_data;
        int         exp_nv;
        bit         exp_perr, exp_ferr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int hs0, vc0;
        vecs[0] = '{8'hA5, 8, 0, 0, 0, 0, 1, 1, 8'hA5, 1, 0, 0};
        vecs[1] = '{8'h35, 7, 1, 0, 1, 0, 1, 1, 8'h35, 1, 0, 0};
        vecs[2] = '{8'h35, 7, 1, 0, 1, 1, 1, 1, 8'h35, 1, 1, 0};
        vecs[3] = '{8'h1F, 5, 1, 1, 0, 0, 0, 1, 8'h35, 0, 0, 1};
        vecs[4] = '{8'h2A, 6, 1, 0, 0, 0, 1, 1, 8'h2A, 1, 0, 0};
        vecs[5] = '{8'h81, 8, 0, 0, 1, 0, 1, 0, 8'h81, 1, 0, 1};
        vecs[6] = '{8'hC3, 8, 1, 1, 1, 0, 1, 1, 8'hC3, 1, 0, 0};
        vecs[7] = '{8'hFF, 5, 1, 0, 0, 0, 1, 1, 8'h1F, 1, 0, 0};

        rx_if.rx_ready = 1'b1;
        #3 rst_n = 1'b0;
        #4;
        chk("rst_valid", rx_if.rx_valid, 0);
        chk("rst_data", rx_if.rx_data, 0);
        chk("rst_errs", {frame_error, parity_error, overrun_error, break_detect}, 0);
        chk("rst_active", rx_active, 0);
        repeat (3) @(negedge uart_clk);
        rst_n = 1'b1;
        repeat (4) tick(1'b1);

        for (int i = 0; i < 8; i++) begin
            ctx = i;
            hs0 = hs_cnt;
            vc0 = vcyc;
            send_frame(vecs[i].d, vecs[i].nb, vecs[i].pen, vecs[i].podd, vecs[i].st2,
                       vecs[i].pflip, vecs[i].s1v, vecs[i].s2v);
            chk("tbl_words", hs_cnt - hs0, vecs[i].exp_nv);
            chk("tbl_vcycles", vcyc - vc0, vecs[i].exp_nv);
            chk("tbl_data", rx_if.rx_data, vecs[i].exp_data);
            chk("tbl_perr", parity_error, vecs[i].exp_perr);
            chk("tbl_ferr", frame_error, vecs[i].exp_ferr);
            chk("tbl_ovr", overrun_error, 0);
            chk("tbl_active", rx_active, 0);
            if (vecs[i].exp_nv != 0) chk("tbl_hsperr", last_perr, vecs[i].exp_perr);
        end

        // False start: six low ticks only.
        ctx = 100;
        hs0 = hs_cnt;
        repeat (6) tick(1'b0);
        chk("fs_active_hi", rx_active, 1);
        repeat (24) tick(1'b1);
        chk("fs_active_lo", rx_active, 0);
        chk("fs_words", hs_cnt - hs0, 0);
        chk("fs_errs", {frame_error, parity_error, overrun_error}, 0);

        // Overrun: two words without acceptance.
        ctx = 200;
        rx_if.rx_ready = 1'b0;
        hs0 = hs_cnt;
        send_frame(8'h11, 8, 0, 0, 0, 0, 1, 1);
        chk("ov_valid1", rx_if.rx_valid, 1);
        chk("ov_data1", rx_if.rx_data, 8'h11);
        chk("ov_ovr1", overrun_error, 0);
        send_frame(8'h22, 8, 0, 0, 0, 0, 1, 1);
        chk("ov_valid2", rx_if.rx_valid, 1);
        chk("ov_data2", rx_if.rx_data, 8'h22);
        chk("ov_ovr2", overrun_error, 1);
        @(negedge uart_clk);
        rx_if.rx_ready = 1'b1;
        repeat (2) @(negedge uart_clk);
        chk("ov_words", hs_cnt - hs0, 1);
        chk("ov_hsdata", last_data, 8'h22);
        chk("ov_hsovr", last_ovr, 1);
        chk("ov_valid3", rx_if.rx_valid, 0);
        chk("ov_ovr3", overrun_error, 0);

        // Line held low for three frame times.
        ctx = 300;
        hs0 = hs_cnt;
        cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        repeat (3 * 10 * OSR) tick(1'b0);
        chk("brk_words", hs_cnt - hs0, 0);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("brk_det", break_detect, 1);
        chk("brk_ferr", frame_error, 0);
        chk("brk_active", rx_active, 1);
`else
        chk("brk_det", break_detect, 0);
        chk("brk_ferr", frame_error, 1);
        chk("brk_active", rx_active, 0);
`endif
        repeat (20) tick(1'b1);
        chk("brk_clear", break_detect, 0);
        chk("brk_idle", rx_active, 0);
        send_frame(8'h5A, 8, 0, 0, 0, 0, 1, 1);
        chk("brk_words2", hs_cnt - hs0, 1);
        chk("brk_data", last_data, 8'h5A);
        chk("brk_ferr2", frame_error, 0);

        // Asynchronous reset in the middle of a byte.
        ctx = 400;
        cfg_data_bits = 2'd3;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (5) tick(1'b0);
        chk("mr_active_pre", rx_active, 1);
        @(negedge uart_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_active", rx_active, 0);
        chk("mr_data", rx_if.rx_data, 0);
        chk("mr_valid", rx_if.rx_valid, 0);
        chk("mr_errs", {frame_error, parity_error, overrun_error, break_detect}, 0);
        rx_serial_sync = 1'b1;
        repeat (3) @(negedge uart_clk);
        rst_n = 1'b1;
        repeat (4) tick(1'b1);
        hs0 = hs_cnt;
        send_frame(8'h3C, 8, 0, 0, 0, 0, 1, 1);
        chk("mr_words", hs_cnt - hs0, 1);
        chk("mr_hsdata", last_data, 8'h3C);

        // Random frames against a word-level reference.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            int nb;
            bit pen, podd, st2, pflip;
            ctx = 500 + i;
            d = 8'($urandom);
            nb = $urandom_range(5, 8);
            pen = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            st2 = 1'($urandom_range(0, 1));
            pflip = pen & 1'($urandom_range(0, 1));
            hs0 = hs_cnt;
            send_frame(d, nb, pen, podd, st2, pflip, 1, 1);
            repeat ($urandom_range(0, 5)) tick(1'b1);
            chk("rnd_words", hs_cnt - hs0, 1);
            chk("rnd_data", last_data, d & 8'((9'd1 << nb) - 9'd1));
            chk("rnd_perr", last_perr, pflip);
            chk("rnd_ferr", frame_error, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter MAX_DATA_WIDTH, default 8, widest data field in bits; legal values 5..8.
REQ-002 SHALL have parameter OVERSAMPLE_RATE, default 16, number of sample_tick pulses per bit; even and >= 8.
REQ-003 SHALL have port uart_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sample_tick  input  1  oversample enable; logic advances only on uart_clk edges where it is high.
REQ-006 SHALL have port rx_serial_sync  input  1  already-synchronised serial line, idle high.
REQ-007 SHALL have port cfg_data_bits  input  2  data length minus 5 (0 = 5 bits, 3 = 8 bits); values above MAX_DATA_WIDTH-5 are clamped to MAX_DATA_WIDTH.
REQ-008 SHALL have ports cfg_parity_en, cfg_parity_odd and cfg_stop2, each input 1, selecting parity on/off, odd/even parity, and 2 versus 1 stop bits.
REQ-009 SHALL have port rx_data  output  MAX_DATA_WIDTH  received word, LSB-aligned, unused upper bits zero.
REQ-010 SHALL have ports rx_valid (output 1) and rx_ready (input 1) forming a valid/ready handshake.
REQ-011 SHALL have ports frame_error, parity_error, overrun_error, break_detect and rx_active, each output 1.

Function
REQ-012 SHALL latch all cfg_* inputs at start detection and hold them for the whole frame; changes mid-frame SHALL have no effect.
REQ-013 SHALL detect a start when, on a sample_tick, the line sampled on the previous tick is high and rx_serial_sync is low. On detection it SHALL enter START with sample_counter = 0.
REQ-014 SHALL use states IDLE, START, DATA, PARITY, STOP1, STOP2 and BRK_WAIT, with sample_counter counting 0..OVERSAMPLE_RATE-1 and wrapping to 0 at each bit boundary.
REQ-015 SHALL decide each bit by majority vote of the samples at counts OSR/2-1, OSR/2 and OSR/2+1; the decision takes effect at count OSR/2+1.
REQ-016 START: if the voted value is 1, SHALL return to IDLE with no output change (false start). Otherwise it SHALL go to DATA at the wrap.
REQ-017 DATA: SHALL shift the voted bit in LSB-first. After the latched bit count, it SHALL go to PARITY if cfg_parity_en is set, else to STOP1.
REQ-018 PARITY: SHALL compute parity_error = XOR(data bits, parity bit) XOR cfg_parity_odd, then go to STOP1.
REQ-019 STOP1 decision, voted 1: SHALL load rx_data and set rx_valid, take parity_error from the frame (0 if parity disabled), and clear frame_error. Next state is STOP2 if cfg_stop2, else IDLE immediately at that decision tick.
REQ-020 STOP1 decision, voted 0: SHALL set frame_error and leave rx_data and rx_valid unchanged, then go to IDLE (break handling per REQ-027/028).
REQ-021 STOP2: a voted 0 SHALL set frame_error without retracting the word already delivered; the block SHALL go to IDLE at the decision tick either way.
REQ-022 SHALL hold rx_valid until the uart_clk cycle in which rx_valid && rx_ready (independent of sample_tick), then clear it.
REQ-023 If a new word is loaded while rx_valid is still high and not being accepted in that cycle, SHALL overwrite rx_data, keep rx_valid high and set overrun_error. overrun_error SHALL clear on the next accepted handshake.
REQ-024 frame_error and parity_error SHALL hold their values until the next STOP1 decision.
REQ-025 rx_active SHALL be high in every state except IDLE.

Reset
REQ-026 On rst_n low, SHALL asynchronously set: state IDLE, counters 0, shift register 0, previous-line register 1, rx_data 0, and rx_valid, frame_error, parity_error, overrun_error, break_detect all 0. Reset mid-frame SHALL discard the partial word.

Configuration
REQ-027 With macro UART_RX_BREAK_DETECT_EN defined: if every data bit, the parity bit (if enabled) and STOP1 all vote 0, SHALL set break_detect instead of frame_error, deliver no word, and enter BRK_WAIT. BRK_WAIT SHALL exit to IDLE and clear break_detect on the first sample_tick with rx_serial_sync high.
REQ-028 Without UART_RX_BREAK_DETECT_EN: break_detect SHALL be constant 0, no BRK_WAIT state SHALL exist, and an all-zero frame SHALL be reported as a frame_error per REQ-020.

Verification
REQ-029 8N1, byte 0xA5, rx_ready high -> rx_data=0xA5, rx_valid one cycle, all errors 0.
REQ-030 7E2, byte 0x35 with correct even parity, then 0x35 with the parity bit flipped -> first word parity_error=0, second parity_error=1, both delivered.
REQ-031 5O1, byte 0x1F with stop bit forced 0 -> frame_error=1, rx_valid stays 0, rx_data unchanged.
REQ-032 Line low for 6 ticks only, then high -> return to IDLE, no rx_valid, no errors.
REQ-033 Two 8N1 bytes 0x11 then 0x22, rx_ready low -> rx_data=0x22, overrun_error=1; raising rx_ready clears rx_valid and overrun_error.
REQ-034 Line low for 3 frames with macro defined -> break_detect=1, no word delivered; line high -> break_detect=0, then byte 0x5A is received correctly. rst_n pulsed mid-byte -> all outputs return to reset values.
